// File: rtl/hpu_ctrl_pkg.sv
// rtl/hpu_ctrl_pkg.sv - HPU control register map, status bits, AXI-Lite codes and FSM states
// Optional macro HPU_CTRL_IRQ_EN adds the IRQ_EN register word index.
package hpu_ctrl_pkg;

  // Word indices (byte offset >> 2)
  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
`ifdef HPU_CTRL_IRQ_EN
  localparam int REG_IRQ_EN   = 2;
`endif
  localparam int REG_VERSION  = 3;
  localparam int REG_SCRATCH  = 4;
  localparam int REG_CFG_BASE = 8;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_RUN_DONE = 1;
  localparam int STAT_MAT_DONE = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AW    = 3'd1,
    ST_W     = 3'd2,
    ST_WRESP = 3'd3,
    ST_RADDR = 3'd4,
    ST_RDATA = 3'd5
  } axil_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/hpu_axil_fsm.sv
// rtl/hpu_axil_fsm.sv - AXI4-Lite handshake FSM with address/data capture and commit/read strobes
module hpu_axil_fsm
  import hpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic              rvalid,
  input  logic              rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic [1:0]        wr_resp,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr
);

  axil_state_t       state;
  logic [ADDR_W-1:0] aw_q;
  logic [ADDR_W-1:0] ar_q;
  logic [31:0]       wd_q;
  logic [3:0]        ws_q;
  logic [1:0]        bresp_q;

  assign awready = (state == ST_IDLE) || (state == ST_W);
  assign wready  = (state == ST_IDLE) || (state == ST_AW);
  assign arready = (state == ST_IDLE);
  assign bvalid  = (state == ST_WRESP);
  assign rvalid  = (state == ST_RDATA);
  assign bresp   = bresp_q;

  // Commit fires on the transition into WRESP; whichever half arrived first comes from the capture regs.
  assign wr_en   = ((state == ST_IDLE) && awvalid && wvalid) ||
                   ((state == ST_AW) && wvalid) ||
                   ((state == ST_W) && awvalid);
  assign wr_addr = (state == ST_AW) ? aw_q : awaddr;
  assign wr_data = (state == ST_W) ? wd_q : wdata;
  assign wr_strb = (state == ST_W) ? ws_q : wstrb;
  assign rd_en   = (state == ST_RADDR);
  assign rd_addr = ar_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      aw_q    <= '0;
      ar_q    <= '0;
      wd_q    <= '0;
      ws_q    <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (wr_en) bresp_q <= wr_resp;
      case (state)
        ST_IDLE: begin
          if (awvalid && wvalid) state <= ST_WRESP;
          else if (awvalid) begin
            state <= ST_AW;
            aw_q  <= awaddr;
          end else if (wvalid) begin
            state <= ST_W;
            wd_q  <= wdata;
            ws_q  <= wstrb;
          end else if (arvalid) begin
            state <= ST_RADDR;
            ar_q  <= araddr;
          end
        end
        ST_AW:    if (wvalid)  state <= ST_WRESP;
        ST_W:     if (awvalid) state <= ST_WRESP;
        ST_WRESP: if (bready)  state <= ST_IDLE;
        ST_RADDR: state <= ST_RDATA;
        ST_RDATA: if (rready)  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hpu_ctrl_regs.sv
// rtl/hpu_ctrl_regs.sv - HPU AXI4-Lite control/status/config register file (optional HPU_CTRL_IRQ_EN)
module hpu_ctrl_regs
  import hpu_ctrl_pkg::*;
#(
  parameter int          NUM_CFG = 4,
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]      S_AXI_AWADDR,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [31:0]            S_AXI_WDATA,
  input  logic [3:0]             S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ADDR_W-1:0]      S_AXI_ARADDR,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [31:0]            S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  input  logic                   mat_fin,
  input  logic                   run_fin,
  input  logic                   busy,
  output logic                   matw,
  output logic                   run,
  output logic                   last,
  output logic [NUM_CFG*32-1:0]  cfg
`ifdef HPU_CTRL_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] IDX_CTRL    = IW'(REG_CTRL);
  localparam logic [IW-1:0] IDX_STATUS  = IW'(REG_STATUS);
  localparam logic [IW-1:0] IDX_VERSION = IW'(REG_VERSION);
  localparam logic [IW-1:0] IDX_SCRATCH = IW'(REG_SCRATCH);
  localparam logic [IW-1:0] IDX_CFG     = IW'(REG_CFG_BASE);
  localparam logic [IW-1:0] IDX_CFG_END = IW'(REG_CFG_BASE + NUM_CFG);
`ifdef HPU_CTRL_IRQ_EN
  localparam logic [IW-1:0] IDX_IRQ_EN  = IW'(REG_IRQ_EN);
`endif

  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [1:0]        wr_resp;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic              wr_ok, ctrl_we;
  logic [2:1]        status_clr;
  logic              run_done, mat_done, run_done_n, mat_done_n;
  logic [31:0]       scratch;
  logic [31:0]       cfg_q [NUM_CFG];
  logic [31:0]       rd_word, rdata_q;
  logic [1:0]        rresp_q;
  logic              unused_addr_lsbs;

  function automatic logic [1:0] decode(input logic [IW-1:0] idx, input logic is_wr);
    logic [1:0] r;
    r = RESP_DECERR;
    if (idx == IDX_CTRL || idx == IDX_STATUS || idx == IDX_SCRATCH ||
        (idx >= IDX_CFG && idx < IDX_CFG_END))
      r = RESP_OKAY;
`ifdef HPU_CTRL_IRQ_EN
    if (idx == IDX_IRQ_EN) r = RESP_OKAY;
`endif
    if (idx == IDX_VERSION) r = is_wr ? RESP_SLVERR : RESP_OKAY;
    return r;
  endfunction

  hpu_axil_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .araddr  (S_AXI_ARADDR),
    .arvalid (S_AXI_ARVALID),
    .arready (S_AXI_ARREADY),
    .rvalid  (S_AXI_RVALID),
    .rready  (S_AXI_RREADY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_resp (wr_resp),
    .rd_en   (rd_en),
    .rd_addr (rd_addr)
  );

  assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};
  assign wr_idx      = wr_addr[ADDR_W-1:2];
  assign rd_idx      = rd_addr[ADDR_W-1:2];
  assign wr_resp     = decode(wr_idx, 1'b1);
  assign wr_ok       = wr_en && (wr_resp == RESP_OKAY);
  assign ctrl_we     = wr_ok && (wr_idx == IDX_CTRL) && wr_strb[0];
  assign status_clr  = (wr_ok && (wr_idx == IDX_STATUS) && wr_strb[0]) ? wr_data[2:1] : 2'b00;
  // A datapath completion in the same cycle as its W1C wins, so no event is lost.
  assign run_done_n  = run_fin | (run_done & ~status_clr[STAT_RUN_DONE]);
  assign mat_done_n  = mat_fin | (mat_done & ~status_clr[STAT_MAT_DONE]);
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
    assign cfg[32*k +: 32] = cfg_q[k];
  end

`ifdef HPU_CTRL_IRQ_EN
  logic [2:1] irq_en, irq_en_n;
  assign irq_en_n = (wr_ok && (wr_idx == IDX_IRQ_EN) && wr_strb[0]) ? wr_data[2:1] : irq_en;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      irq_en <= irq_en_n;
      irq    <= (mat_done_n & irq_en_n[STAT_MAT_DONE]) | (run_done_n & irq_en_n[STAT_RUN_DONE]);
    end
  end
`endif

  always_comb begin
    rd_word = '0;
    if (rd_idx == IDX_CTRL) rd_word[2:0] = {last, run, matw};
    else if (rd_idx == IDX_STATUS) begin
      rd_word[STAT_BUSY]     = busy;
      rd_word[STAT_RUN_DONE] = run_done;
      rd_word[STAT_MAT_DONE] = mat_done;
    end
    else if (rd_idx == IDX_VERSION) rd_word = VERSION;
    else if (rd_idx == IDX_SCRATCH) rd_word = scratch;
`ifdef HPU_CTRL_IRQ_EN
    else if (rd_idx == IDX_IRQ_EN) rd_word[2:1] = irq_en;
`endif
    else begin
      for (int k = 0; k < NUM_CFG; k++)
        if (rd_idx == IDX_CFG + IW'(k)) rd_word = cfg_q[k];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      matw     <= 1'b0;
      run      <= 1'b0;
      last     <= 1'b0;
      run_done <= 1'b0;
      mat_done <= 1'b0;
      scratch  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
    end else begin
      if (ctrl_we) {last, run, matw} <= wr_data[2:0];
      else if (mat_fin) matw <= 1'b0;
      run_done <= run_done_n;
      mat_done <= mat_done_n;
      if (wr_ok && (wr_idx == IDX_SCRATCH))
        scratch <= apply_strb(scratch, wr_data, wr_strb);
      for (int k = 0; k < NUM_CFG; k++)
        if (wr_ok && (wr_idx == IDX_CFG + IW'(k)))
          cfg_q[k] <= apply_strb(cfg_q[k], wr_data, wr_strb);
      if (rd_en) begin
        rdata_q <= rd_word;
        rresp_q <= decode(rd_idx, 1'b0);
      end
    end
  end

endmodule

// File: tb/tb_hpu_ctrl_regs.sv
// tb/tb_hpu_ctrl_regs.sv - randomized self-checking bench for hpu_ctrl_regs against a behavioural model
module tb_hpu_ctrl_regs;

  localparam int NUM_CFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        mat_fin, run_fin, busy, matw, run, last;
  logic [NUM_CFG*32-1:0] cfg;
`ifdef HPU_CTRL_IRQ_EN
  logic        irq;
`endif

  hpu_ctrl_regs #(.NUM_CFG(NUM_CFG), .ADDR_W(12), .VERSION(32'h0001_0000)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .mat_fin(mat_fin), .run_fin(run_fin), .busy(busy),
    .matw(matw), .run(run), .last(last), .cfg(cfg)
`ifdef HPU_CTRL_IRQ_EN
    , .irq(irq)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: register contents as the software-visible map describes them
  logic [31:0] m_cfg [NUM_CFG];
  logic [31:0] m_scratch;
  logic [2:0]  m_ctrl;
  logic        m_run_done, m_mat_done;
  logic [2:1]  m_irq_en;

  task automatic m_reset();
    for (int k = 0; k < NUM_CFG; k++) m_cfg[k] = 0;
    m_scratch = 0; m_ctrl = 0; m_run_done = 0; m_mat_done = 0; m_irq_en = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1:0] m_resp(input logic [11:0] a, input bit wr);
    int i = int'(a[11:2]);
    if (i == 0 || i == 1 || i == 4 || (i >= 8 && i < 8 + NUM_CFG)) return 2'b00;
`ifdef HPU_CTRL_IRQ_EN
    if (i == 2) return 2'b00;
`endif
    if (i == 3) return wr ? 2'b10 : 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int i = int'(a[11:2]);
    if (i == 0) return {29'd0, m_ctrl};
    if (i == 1) return {29'd0, m_mat_done, m_run_done, busy};
`ifdef HPU_CTRL_IRQ_EN
    if (i == 2) return {29'd0, m_irq_en, 1'b0};
`endif
    if (i == 3) return 32'h0001_0000;
    if (i == 4) return m_scratch;
    if (i >= 8 && i < 8 + NUM_CFG) return m_cfg[i-8];
    return 32'd0;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int i = int'(a[11:2]);
    if (m_resp(a, 1) != 2'b00) return;
    if (i == 0 && s[0]) m_ctrl = d[2:0];
    if (i == 1 && s[0]) begin
      if (d[1]) m_run_done = 0;
      if (d[2]) m_mat_done = 0;
    end
    if (i == 2 && s[0]) m_irq_en = d[2:1];
    if (i == 4) m_scratch = merge(m_scratch, d, s);
    if (i >= 8 && i < 8 + NUM_CFG) m_cfg[i-8] = merge(m_cfg[i-8], d, s);
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_CFG*32-1:0] ec;
    for (int k = 0; k < NUM_CFG; k++) ec[32*k +: 32] = m_cfg[k];
    chk({tag, ".ctrl"}, {last, run, matw}, m_ctrl);
    chk({tag, ".cfg"}, cfg, ec);
`ifdef HPU_CTRL_IRQ_EN
    chk({tag, ".irq"}, irq, (m_mat_done & m_irq_en[2]) | (m_run_done & m_irq_en[1]));
`endif
  endtask

  task automatic pulse_fin(input bit mat, input bit rn);
    mat_fin = mat; run_fin = rn;
    @(posedge clk); #1;
    mat_fin = 0; run_fin = 0;
    if (mat) begin m_ctrl[0] = 0; m_mat_done = 1; end
    if (rn) m_run_done = 1;
  endtask

  // mode: 0 AW+W together, 1 AW first, 2 W first. coin: fins asserted on the commit edge (mode 0).
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int mode, input int bdly, input bit fin_in_hold, input bit coin);
    int n = 0;
    bit aw_d = 0, w_d = 0, awr, wr;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (mode != 2); wvalid = (mode != 1);
    if (coin) begin mat_fin = 1; run_fin = 1; end
    while (!(aw_d && w_d) && n < 20) begin
      awr = awready; wr = wready;
      @(posedge clk); #1; n++;
      mat_fin = 0; run_fin = 0;
      if (awvalid && awr) begin aw_d = 1; awvalid = 0; end
      if (wvalid && wr) begin w_d = 1; wvalid = 0; end
      if (n >= 2 && !aw_d) awvalid = 1;
      if (n >= 2 && !w_d) wvalid = 1;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake", {aw_d, w_d}, 2'b11);
    if (coin) m_ctrl[0] = 0;
    m_write(a, d, s);
    if (coin) begin m_run_done = 1; m_mat_done = 1; end
    chk("bvalid_at_commit", bvalid, 1'b1);
    chk("bresp", bresp, m_resp(a, 1));
    check_outputs("wr");
    for (int i = 0; i < bdly; i++) begin
      if (fin_in_hold && i == 1) mat_fin = 1;
      @(posedge clk); #1;
      if (mat_fin) begin mat_fin = 0; m_ctrl[0] = 0; m_mat_done = 1; end
    end
    if (bdly > 0) chk("bvalid_held", bvalid, 1'b1);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("bvalid_drop", bvalid, 1'b0);
    check_outputs("wr_done");
  endtask

  task automatic axi_read(input logic [11:0] a, input int rdly, output logic [31:0] d);
    int n = 0;
    bit done = 0, arr;
    logic [31:0] exp_d;
    araddr = a; arvalid = 1;
    exp_d = m_read(a);
    while (!done && n < 20) begin
      arr = arready;
      @(posedge clk); #1; n++;
      if (arr) begin done = 1; arvalid = 0; end
    end
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 10) begin @(posedge clk); #1; n++; end
    chk("rvalid", rvalid, 1'b1);
    repeat (rdly) begin @(posedge clk); #1; end
    d = rdata;
    chk("rdata", rdata, exp_d);
    chk("rresp", rresp, m_resp(a, 0));
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("rvalid_drop", rvalid, 1'b0);
  endtask

  function automatic logic [11:0] pick_addr();
    logic [11:0] a;
    case ($urandom_range(0, 9))
      0: a = 12'h000;
      1: a = 12'h004;
      2: a = 12'h008;
      3: a = 12'h00C;
      4: a = 12'h010;
      5, 6, 7: a = 12'h020 + 12'($urandom_range(0, NUM_CFG - 1) * 4);
      8: a = 12'($urandom);
      default: a = 12'h014;
    endcase
    a[1:0] = 2'($urandom);
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    rst_n = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; mat_fin = 0; run_fin = 0; busy = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", {awready, wready, arready}, 3'b111);
    check_outputs("rst");

    axi_write(12'h020, 32'h0000_000B, 4'hF, 0, 0, 0, 0);
    chk("cfg0_b", cfg[31:0], 32'h0000_000B);
    axi_read(12'h020, 0, d);

    axi_write(12'h010, 32'hAABB_CCDD, 4'hF, 2, 1, 0, 0);
    axi_write(12'h010, 32'h0000_1100, 4'h2, 0, 0, 0, 0);
    axi_read(12'h010, 2, d);
    chk("scratch_strb", d, 32'hAABB_11DD);

    axi_write(12'h000, 32'h1, 4'hF, 1, 0, 0, 0);
    pulse_fin(1, 0);
    chk("matw_cleared", matw, 1'b0);
    axi_read(12'h004, 0, d);
    chk("status_mat_done", d, 32'h4);
    axi_write(12'h004, 32'h4, 4'hF, 0, 0, 0, 0);
    axi_read(12'h004, 0, d);
    chk("status_w1c", d, 32'h0);

    axi_read(12'h3F0, 0, d);
    chk("decerr_rresp", rresp, 2'b11);
    axi_write(12'h00C, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
    axi_read(12'h00C, 1, d);
    chk("version", d, 32'h0001_0000);

    axi_write(12'h000, 32'h1, 4'hF, 0, 5, 1, 0);
    chk("commit_once_matw", matw, 1'b0);

    pulse_fin(0, 1);
    axi_write(12'h004, 32'h2, 4'hF, 0, 0, 0, 1);
    axi_write(12'h000, 32'h7, 4'hF, 0, 0, 0, 1);
    chk("sw_wins_matw", matw, 1'b1);

`ifdef HPU_CTRL_IRQ_EN
    axi_write(12'h004, 32'h6, 4'hF, 0, 0, 0, 0);
    axi_write(12'h008, 32'h2, 4'hF, 0, 0, 0, 0);
    pulse_fin(0, 1);
    chk("irq_set", irq, 1'b1);
    axi_write(12'h004, 32'h2, 4'hF, 0, 0, 0, 0);
    chk("irq_clr", irq, 1'b0);
`endif

    for (int it = 0; it < 120; it++) begin
      busy = 1'($urandom);
      if ($urandom_range(0, 5) == 0) pulse_fin(1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0)
        axi_write(pick_addr(), $urandom, 4'($urandom), $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'($urandom), 1'b0);
      else
        axi_read(pick_addr(), $urandom_range(0, 3), d);
    end

    araddr = 12'h020; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    @(posedge clk); #1;
    chk("pre_reset_rvalid", rvalid, 1'b1);
    rst_n = 0;
    #2;
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_cfg", cfg, '0);
    chk("reset_ctrl", {last, run, matw}, 3'b000);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    m_reset();
    busy = 0;
    axi_read(12'h010, 0, d);
    axi_read(12'h004, 0, d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
